// File: rtl/aidc_lite_pkg.sv
// Shared constants, state encoding and helpers for the AIDC Lite code-select slice.
package aidc_lite_pkg;

  localparam int WORD_W    = 64;
  localparam int BLK_WORDS = 8;
  localparam int LINE_W    = 512;
  localparam int ADDR_W    = 3;
  localparam int CNT_W     = 4;
  localparam int TIMER_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  // 2-bit encoding prefix owned by each concatenator lane
  localparam logic [1:0] LANE_PREFIX_0 = 2'b00;
  localparam logic [1:0] LANE_PREFIX_1 = 2'b01;
  localparam logic [1:0] LANE_PREFIX_2 = 2'b10;
  localparam logic [1:0] LANE_PREFIX_3 = 2'b11;

  // Word idx of a raw line, word 0 being the most significant 64 bits
  function automatic logic [WORD_W-1:0] raw_word(input logic [LINE_W-1:0] line,
                                                 input logic [ADDR_W-1:0] idx);
    raw_word = line[(LINE_W - WORD_W) - int'(idx) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/aidc_lite_lane_buf.sv
// One concatenator lane: 8-word capture buffer plus seen/complete/fail flags and word count.
module aidc_lite_lane_buf
  import aidc_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              done_i,
  input  logic              fail_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              complete_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  wcnt_o
);

  logic [WORD_W-1:0] mem_q [BLK_WORDS];
  logic              seen_q, seen_d, seen_b;
  logic              complete_q, complete_d, complete_b;
  logic              fail_q, fail_d, fail_b;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, wcnt_b;
  logic [CNT_W-1:0]  addr_p1_s;
  logic              wr_ok_s;

  // A clear folds into the same cycle so start-cycle writes are kept
  always_comb begin
    if (clr_i) begin
      seen_b     = 1'b0;
      complete_b = 1'b0;
      fail_b     = 1'b0;
      wcnt_b     = 4'd0;
    end else begin
      seen_b     = seen_q;
      complete_b = complete_q;
      fail_b     = fail_q;
      wcnt_b     = wcnt_q;
    end
    wr_ok_s   = en_i && wr_i && !complete_b;
    addr_p1_s = {1'b0, addr_i} + 4'd1;
    seen_d    = seen_b | wr_ok_s;
    if (wr_ok_s && (addr_p1_s > wcnt_b)) begin
      wcnt_d = addr_p1_s;
    end else begin
      wcnt_d = wcnt_b;
    end
    // A done with no write yet on this line is the stale level of the previous one
    if (en_i && !complete_b && done_i && (seen_b || wr_i)) begin
      complete_d = 1'b1;
      fail_d     = fail_i;
    end else begin
      complete_d = complete_b;
      fail_d     = fail_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= 1'b0;
      complete_q <= 1'b0;
      fail_q     <= 1'b0;
      wcnt_q     <= 4'd0;
    end else begin
      seen_q     <= seen_d;
      complete_q <= complete_d;
      fail_q     <= fail_d;
      wcnt_q     <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[addr_i] <= data_i;
    end
  end

  // Bypass lets the selection cycle read a word written in that same cycle
  assign rd_data_o  = (wr_ok_s && (addr_i == rd_idx_i)) ? data_i : mem_q[rd_idx_i];
  assign complete_o = complete_d;
  assign fail_o     = fail_d;
  assign wcnt_o     = wcnt_d;

endmodule

// File: rtl/aidc_lite_code_select.sv
// Collects per-lane encodings, picks the shortest good one (or the raw line) and streams it out.
module aidc_lite_code_select
  import aidc_lite_pkg::*;
#(
  parameter int NUM_LANE = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [LINE_W-1:0]          raw_data_i,
  input  logic [NUM_LANE-1:0]        lane_valid_i,
  input  logic [ADDR_W*NUM_LANE-1:0] lane_addr_i,
  input  logic [WORD_W*NUM_LANE-1:0] lane_data_i,
  input  logic [NUM_LANE-1:0]        lane_done_i,
  input  logic [NUM_LANE-1:0]        lane_fail_i,
  output logic                       busy_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WORD_W-1:0]          data_o,
  output logic                       sop_o,
  output logic                       eop_o,
  output logic                       comp_o,
  output logic [1:0]                 sel_o,
  output logic [CNT_W-1:0]           len_o
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              busy_q, busy_d, valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic              comp_q, comp_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LINE_W-1:0] raw_q, raw_d;

  logic              eop_hs_s, start_acc_s, lane_en_s, sel_trig_s;
  logic              found_s, use_comp_s, fetch_comp_s;
  logic [1:0]        win_s, fetch_sel_s;
  logic [CNT_W-1:0]  win_len_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [WORD_W-1:0] fetch_lane_s, fetch_word_s;
  logic [NUM_LANE-1:0] complete_s, fail_s;
  logic [CNT_W-1:0]  wcnt_s    [NUM_LANE];
  logic [WORD_W-1:0] rd_data_s [NUM_LANE];

  assign eop_hs_s    = valid_q && ready_i && eop_q;
  assign start_acc_s = start_i && ((state_q == ST_IDLE) || ((state_q == ST_SEND) && eop_hs_s));
  assign lane_en_s   = (state_q == ST_COLLECT) || start_acc_s;
  assign sel_trig_s  = (state_q == ST_COLLECT) && ((&complete_s) || (timer_q >= TIMER_MAX));

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    aidc_lite_lane_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (start_acc_s),
      .en_i       (lane_en_s),
      .wr_i       (lane_valid_i[g]),
      .addr_i     (lane_addr_i[ADDR_W*g +: ADDR_W]),
      .data_i     (lane_data_i[WORD_W*g +: WORD_W]),
      .done_i     (lane_done_i[g]),
      .fail_i     (lane_fail_i[g]),
      .rd_idx_i   (rd_idx_s),
      .rd_data_o  (rd_data_s[g]),
      .complete_o (complete_s[g]),
      .fail_o     (fail_s[g]),
      .wcnt_o     (wcnt_s[g])
    );
  end

  // Shortest complete, non-failing lane; strict compare keeps ties on the lowest index
  always_comb begin
    found_s   = 1'b0;
    win_s     = 2'd0;
    win_len_s = 4'd0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (complete_s[i] && !fail_s[i] && (wcnt_s[i] != 4'd0) &&
          (!found_s || (wcnt_s[i] < win_len_s))) begin
        found_s   = 1'b1;
        win_s     = 2'(i);
        win_len_s = wcnt_s[i];
      end else begin
        found_s   = found_s;
      end
    end
    use_comp_s = found_s && (&complete_s);
  end

  always_comb begin
    if (state_q == ST_COLLECT) begin
      rd_idx_s     = 3'd0;
      fetch_comp_s = use_comp_s;
      fetch_sel_s  = win_s;
    end else begin
      rd_idx_s     = ptr_q + 3'd1;
      fetch_comp_s = comp_q;
      fetch_sel_s  = sel_q;
    end
    fetch_lane_s = rd_data_s[0];
    for (int i = 0; i < NUM_LANE; i++) begin
      if (fetch_sel_s == 2'(i)) begin
        fetch_lane_s = rd_data_s[i];
      end else begin
        fetch_lane_s = fetch_lane_s;
      end
    end
    fetch_word_s = fetch_comp_s ? fetch_lane_s : raw_word(raw_q, rd_idx_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE:    state_d = start_i ? ST_COLLECT : ST_IDLE;
      ST_COLLECT: state_d = sel_trig_s ? ST_SEND : ST_COLLECT;
      ST_SEND: begin
        if (eop_hs_s) begin
          state_d = start_i ? ST_COLLECT : ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    comp_d  = comp_q;
    sel_d   = sel_q;
    len_d   = len_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
      ST_COLLECT: begin
        if (sel_trig_s) begin
          valid_d = 1'b1;
          ptr_d   = 3'd0;
          sop_d   = 1'b1;
          comp_d  = use_comp_s;
          sel_d   = use_comp_s ? win_s : 2'd0;
          len_d   = use_comp_s ? win_len_s : CNT_W'(BLK_WORDS);
          eop_d   = (len_d == 4'd1);
          data_d  = fetch_word_s;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (valid_q && ready_i) begin
          if (eop_q) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            data_d  = 64'd0;
          end else begin
            ptr_d   = ptr_q + 3'd1;
            data_d  = fetch_word_s;
            sop_d   = 1'b0;
            eop_d   = (({1'b0, ptr_q} + 4'd2) == len_q);
          end
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    raw_d   = start_acc_s ? raw_data_i : raw_q;
    if (state_q == ST_COLLECT) begin
      timer_d = (timer_q >= TIMER_MAX) ? timer_q : timer_q + 7'd1;
    end else begin
      timer_d = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      comp_q  <= 1'b0;
      sel_q   <= 2'd0;
      len_q   <= 4'd0;
      data_q  <= 64'd0;
      ptr_q   <= 3'd0;
      timer_q <= 7'd0;
      raw_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      comp_q  <= comp_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      raw_q   <= raw_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign comp_o  = comp_q;
  assign sel_o   = sel_q;
  assign len_o   = len_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_aidc_lite_code_select.sv
// Scoreboard bench for aidc_lite_code_select: expected words queued at stimulus, checked at handshake.
module tb_aidc_lite_code_select;

  localparam int NL      = 2;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [511:0]   raw_data_i = '0;
  logic [NL-1:0]  lane_valid_i = '0;
  logic [3*NL-1:0]  lane_addr_i = '0;
  logic [64*NL-1:0] lane_data_i = '0;
  logic [NL-1:0]  lane_done_i = '0;
  logic [NL-1:0]  lane_fail_i = '0;
  logic           busy_o, valid_o, sop_o, eop_o, comp_o;
  logic           ready_i = 1'b0;
  logic [63:0]    data_o;
  logic [1:0]     sel_o;
  logic [3:0]     len_o;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        comp;
    logic [1:0]  sel;
    logic [3:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] lw [NL][8];
  logic [511:0] raw_line;
  int          n_chk = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  bit          rand_rdy = 1'b0;
  logic        man_rdy = 1'b0;
  logic        stall_r = 1'b0;
  logic [63:0] held_data = '0;
  logic        held_eop = 1'b0;

  aidc_lite_code_select #(.NUM_LANE(NL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .raw_data_i(raw_data_i),
    .lane_valid_i(lane_valid_i), .lane_addr_i(lane_addr_i), .lane_data_i(lane_data_i),
    .lane_done_i(lane_done_i), .lane_fail_i(lane_fail_i), .busy_o(busy_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .sop_o(sop_o),
    .eop_o(eop_o), .comp_o(comp_o), .sel_o(sel_o), .len_o(len_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ready_i follows either a random pattern or the manual level
  initial forever begin
    @(posedge clk);
    #2;
    ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : man_rdy;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      stall_r <= 1'b0;
    end else begin
      if (stall_r && valid_o) begin
        check_eq("hold_data", data_o, held_data);
        check_eq("hold_eop", 64'(eop_o), 64'(held_eop));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("data", data_o, e.data);
          check_eq("sop", 64'(sop_o), 64'(e.sop));
          check_eq("eop", 64'(eop_o), 64'(e.eop));
          check_eq("comp", 64'(comp_o), 64'(e.comp));
          check_eq("sel", 64'(sel_o), 64'(e.sel));
          check_eq("len", 64'(len_o), 64'(e.len));
        end
        hs_cnt <= hs_cnt + 1;
      end
      stall_r   <= valid_o && !ready_i;
      held_data <= data_o;
      held_eop  <= eop_o;
    end
  end

  task automatic start_line(input bit keep_done);
    for (int k = 0; k < 16; k++) raw_line[32*k +: 32] = $urandom;
    @(posedge clk);
    #1;
    check_eq("start_idle", 64'(busy_o), 64'd0);
    start_i    = 1'b1;
    raw_data_i = raw_line;
    if (!keep_done) begin
      lane_done_i = '0;
      lane_fail_i = '0;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic lane_wr(input int l, input int a);
    logic [63:0] w;
    w = {$urandom, $urandom};
    lw[l][a] = w;
    lane_valid_i[l]          = 1'b1;
    lane_addr_i[3*l +: 3]    = 3'(a);
    lane_data_i[64*l +: 64]  = w;
    @(posedge clk);
    #1;
    lane_valid_i = '0;
  endtask

  task automatic set_done(input int l, input bit f);
    lane_done_i[l] = 1'b1;
    lane_fail_i[l] = f;
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input bit comp, input int sel, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.data = comp ? lw[sel][k] : raw_line[511-64*k -: 64];
      e.sop  = (k == 0);
      e.eop  = (k == len - 1);
      e.comp = comp;
      e.sel  = 2'(sel);
      e.len  = 4'(len);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", 64'(n < budget), 64'd1);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic line_3v5();
    start_line(1'b0);
    for (int a = 0; a < 3; a++) lane_wr(0, a);
    for (int a = 0; a < 5; a++) lane_wr(1, a);
    push_block(1'b1, 0, 3);
    set_done(1, 1'b0);
    set_done(0, 1'b0);
    wait_idle(500);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int base;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_sop", 64'(sop_o), 64'd0);
    check_eq("rst_eop", 64'(eop_o), 64'd0);
    check_eq("rst_comp", 64'(comp_o), 64'd0);
    check_eq("rst_sel", 64'(sel_o), 64'd0);
    check_eq("rst_len", 64'(len_o), 64'd0);
    check_eq("rst_data", data_o, 64'd0);
    rst_n = 1'b1;

    // shortest lane wins
    rand_rdy = 1'b1;
    line_3v5();

    // every lane fails: raw fallback
    start_line(1'b0);
    for (int a = 0; a < 8; a++) begin
      lane_wr(0, a);
      lane_wr(1, a);
    end
    push_block(1'b0, 0, 8);
    set_done(0, 1'b1);
    set_done(1, 1'b1);
    wait_idle(500);

    // equal lengths resolve to lane 0
    start_line(1'b0);
    lane_wr(1, 0); lane_wr(1, 1);
    set_done(1, 1'b0);
    lane_wr(0, 0); lane_wr(0, 1);
    push_block(1'b1, 0, 2);
    set_done(0, 1'b0);
    wait_idle(500);

    // 4-cycle stall on word 1
    rand_rdy = 1'b0;
    man_rdy  = 1'b0;
    start_line(1'b0);
    for (int a = 0; a < 5; a++) lane_wr(0, a);
    for (int a = 0; a < 6; a++) lane_wr(1, a);
    push_block(1'b1, 0, 5);
    set_done(0, 1'b0);
    set_done(1, 1'b0);
    n = 0;
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_valid", 64'(n < 100), 64'd1);
    @(posedge clk); #1; man_rdy = 1'b1;
    @(posedge clk); #1; man_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    man_rdy = 1'b1;
    wait_idle(500);

    // stale done levels, lane 1 silent: only the timer ends the collection
    rand_rdy = 1'b1;
    start_line(1'b1);
    lane_wr(0, 0);
    push_block(1'b0, 0, 8);
    n = 0;
    while (!valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_latency", 64'((n >= TIMEOUT - 4) && (n <= TIMEOUT + 4)), 64'd1);
    wait_idle(500);

    // reset in the middle of a block, then a clean block
    rand_rdy = 1'b0;
    man_rdy  = 1'b1;
    start_line(1'b0);
    for (int a = 0; a < 4; a++) lane_wr(0, a);
    for (int a = 0; a < 6; a++) lane_wr(1, a);
    push_block(1'b1, 0, 4);
    base = hs_cnt;
    set_done(0, 1'b0);
    set_done(1, 1'b0);
    n = 0;
    while (!(hs_cnt == base + 3 && valid_o) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("reach_word2", 64'(n < 100), 64'd1);
    check_eq("word2_shown", data_o, lw[0][2]);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(valid_o), 64'd0);
    check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
    check_eq("mid_rst_eop", 64'(eop_o), 64'd0);
    exp_q.delete();
    lane_done_i = '0;
    lane_fail_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rand_rdy = 1'b1;
    line_3v5();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aidc_lite_code_select.md
Name: aidc_lite_code_select

Overview:
- Sits downstream of NUM_LANE code-concatenation units. Each unit runs one AIDC Lite encoding, with its own 2-bit prefix, over the same 512-bit line.
- Captures each lane's 64-bit word writes into a per-lane 8-word buffer and waits for every lane to report done.
- Selects the shortest non-failing encoding, or falls back to the raw line, and streams the result out as a valid/ready word stream.
- Is the only consumer of the concatenators' valid/addr/data/done/fail outputs.

Parameters:
- NUM_LANE, 2, number of concatenator lanes (1..4).
- TIMEOUT, 64, cycles allowed in COLLECT before forced raw fallback (must be >8).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  new line begins; asserted in the same cycle as the lanes' sop_i
- raw_data_i  in  512  uncompressed line, sampled when start_i is accepted
- lane_valid_i  in  NUM_LANE  per-lane word write strobe
- lane_addr_i  in  3*NUM_LANE  per-lane word index
- lane_data_i  in  64*NUM_LANE  per-lane word
- lane_done_i  in  NUM_LANE  per-lane done (level)
- lane_fail_i  in  NUM_LANE  per-lane fail (level, valid with done)
- busy_o  out  1  high in every state except IDLE
- valid_o  out  1  output word valid
- ready_i  in  1  output word accepted
- data_o  out  64  output word; word 0 is the MSB-first start of the block
- sop_o / eop_o  out  1 / 1  first / last word of block
- comp_o  out  1  1 = compressed block, 0 = raw fallback
- sel_o  out  2  winning lane index; 0 when comp_o=0
- len_o  out  4  number of words in the block (1..8), constant for the block

Behaviour:
- Reset values: state=IDLE, busy_o=0, valid_o=0, sop_o=0, eop_o=0, comp_o=0, sel_o=0, len_o=0, data_o=0. All lane flags and the timer are cleared. Buffer contents are don't-care.
- FSM states: IDLE, COLLECT, SEND.
- IDLE:
  - On start_i: capture raw_data_i, clear per-lane seen/complete flags and word counts, clear the timer, go to COLLECT.
  - Lane writes in the start cycle are captured.
- COLLECT, per lane i:
  - lane_valid_i[i] writes lane_data_i into buf[i][addr]. wcnt[i] = max(wcnt[i], addr+1). Set seen[i].
  - complete[i] sets when lane_done_i[i] && (seen[i] || lane_valid_i[i]). This rejects the stale done that is still high from the previous line. A same-cycle sop/eop lane completes on its single write.
  - fail[i] is latched at the complete edge.
  - Writes after complete[i] are ignored.
- Selection: when all lanes are complete, or the timer reaches TIMEOUT:
  - Winner = lane with complete & ~fail and minimum wcnt; ties go to the lowest index.
  - If no such lane exists, or on timeout: comp_o=0, len_o=8, data comes from raw words, MSB word first.
  - Otherwise comp_o=1, sel_o=winner, len_o=wcnt[winner].
  - Go to SEND. valid_o rises on the next cycle, which gives 1 cycle of latency from the final lane done to the first valid_o.
- SEND:
  - valid_o=1. data_o = word[ptr]. sop_o = (ptr==0). eop_o = (ptr==len_o-1).
  - valid_o, data_o, sop_o, eop_o, comp_o, sel_o and len_o are held stable while ready_i=0.
  - On valid_o && ready_i: ptr++. On the eop handshake: valid_o=0 next cycle, go to IDLE.
  - Back-to-back: a start_i in the same cycle as the eop handshake is accepted, going to COLLECT directly.
- start_i while busy_o=1 (except the eop-handshake cycle) is ignored. Upstream must not do this; the bench asserts it never happens.
- Timer: 7-bit, saturates at TIMEOUT, runs only in COLLECT.
- rst_n asserted mid-COLLECT or mid-SEND: immediate return to reset values; the partial block is discarded and no eop is emitted.
- wcnt is 4 bits (0..8). A complete lane with wcnt=0 is treated as fail.

Decomposition:
- Shared package aidc_lite_pkg: WORD_W=64, BLK_WORDS=8, LINE_W=512, ADDR_W=3, state enum {IDLE, COLLECT, SEND}, prefix constants per lane.
- Sub-module aidc_lite_lane_buf, instantiated NUM_LANE times: 8x64 storage, seen/complete/fail flags, wcnt tracking, clear input, read port by index.
- Top level: FSM, selection comparator, timer, raw buffer, output mux.

Test Plan:
- Lane0 writes 3 words (addr 0..2) + done fail=0; lane1 writes 5 words + done fail=0 -> sop..eop of 3 words, comp_o=1, sel_o=0, len_o=3, data equals lane0 words in order.
- Both lanes write 8 words then done fail=1 -> 8 raw words emitted MSB-first, comp_o=0, sel_o=0, len_o=8.
- Lane1 done with 2 words, lane0 done with 2 words, no fails -> tie broken to sel_o=0, len_o=2.
- ready_i low for 4 cycles mid-block after word 1 -> valid_o and data_o = word 1 held, no word skipped or duplicated, eop on word len_o-1.
- Lane done left high from the previous line, lane1 never writes -> no selection until TIMEOUT=64 cycles, then raw fallback with comp_o=0.
- rst_n pulsed low during SEND word 2 -> valid_o=0 immediately, busy_o=0; the next start_i produces a correct full block.
